mul_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one sequential 32-bit multiplier (start/finish handshake, 64-bit product) between NREQ requesters.
- Latches the winning requester's operands and pulses the multiplier start.
- Waits for the multiplier's finish, then returns the 64-bit product to the winner with a one-cycle done pulse.
- Sits between client blocks (ALU/MDU, DSP loops) and the shared multiplier instance.

---
 rtl/mul_rr_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mul_rr_scheduler.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one sequential 32x32 multiplier between NREQ requesters.
// Define MUL_TIMEOUT_EN to build a watchdog that aborts a multiply after TIMEOUT_CYCLES.
module mul_rr_scheduler #(
    parameter int NREQ           = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   a_flat,
    input  logic [32*NREQ-1:0]   b_flat,
    output logic [NREQ-1:0]      done,
    output logic [63:0]          res,
    output logic                 err,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic                 mul_start,
    input  logic                 mul_finish,
    input  logic [63:0]          mul_p
);

    if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mul_rr_scheduler: invalid parameter combination");
    end

    // Handshakes: requester i holds req[i] with stable operands until its one-cycle done[i].
    // The multiplier gets a one-cycle mul_start and answers with a mul_finish level; that
    // level must be seen low after the start before a rising finish is taken as the result.
    typedef enum logic [2:0] {S_IDLE, S_START, S_CLR, S_WAIT, S_RESP} state_t;

    state_t         state;
    logic [IDW-1:0] last;
    logic           found;
    logic [IDW-1:0] pick;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           wd_hit;

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        logic           hi_any;
        logic           lo_any;
        logic [IDW-1:0] hi;
        logic [IDW-1:0] lo;
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi     = '0;
        lo     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo     = IDW'(i);
                lo_any = 1'b1;
                if (i > int'(last)) begin
                    hi     = IDW'(i);
                    hi_any = 1'b1;
                end
            end
        end
        found = hi_any | lo_any;
        pick  = hi_any ? hi : lo;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == pick) begin
                sel_a = a_flat[32*i +: 32];
                sel_b = b_flat[32*i +: 32];
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt;
    logic          err_q;

    assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign err    = err_q;

    // Counts cycles spent in CLR and WAIT; restarts with every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                wd_cnt <= '0;
            end else if ((state == S_CLR || state == S_WAIT) && !wd_hit) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (state == S_WAIT && mul_finish) begin
                err_q <= 1'b0;
            end else if ((state == S_CLR || state == S_WAIT) && wd_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last      <= IDW'(NREQ - 1);
            grant_id  <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            done      <= '0;
            res       <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_id  <= pick;
                        last      <= pick;
                        mul_a     <= sel_a;
                        mul_b     <= sel_b;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    mul_start <= 1'b0;
                    state     <= S_CLR;
                end
                S_CLR: begin
                    if (wd_hit) begin
                        res   <= '0;
                        done  <= NREQ'(1) << grant_id;
                        state <= S_RESP;
                    end else if (!mul_finish) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mul_finish) begin
                        res   <= mul_p;
                        done  <= NREQ'(1) << grant_id;
                        state <= S_RESP;
                    end else if (wd_hit) begin
                        res   <= '0;
                        done  <= NREQ'(1) << grant_id;
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Self-checking bench for mul_rr_scheduler: directed vectors, corner sequences and random traffic
// against a round-robin reference model with a behavioural sequential multiplier.
module tb_mul_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int EW = IDW + 64;

  logic clk;
  logic rst_n;
  logic [NREQ-1:0] req;
  logic [32*NREQ-1:0] a_flat;
  logic [32*NREQ-1:0] b_flat;
  logic [NREQ-1:0] done;
  logic [63:0] res;
  logic err;
  logic busy;
  logic [IDW-1:0] grant_id;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic mul_start;
  logic mul_finish;
  logic [63:0] mul_p;

  logic [31:0] a_op[NREQ];
  logic [31:0] b_op[NREQ];

  int n_vec;
  int n_err;

  // multiplier model controls
  logic auto_finish;
  logic [63:0] auto_p;
  logic man_mode;
  logic man_finish;
  logic [63:0] man_p;
  int fixed_lat;
  logic to_mode;

  mul_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .a_flat(a_flat),
    .b_flat(b_flat),
    .done(done),
    .res(res),
    .err(err),
    .busy(busy),
    .grant_id(grant_id),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_start(mul_start),
    .mul_finish(mul_finish),
    .mul_p(mul_p)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign a_flat[32*g +: 32] = a_op[g];
    assign b_flat[32*g +: 32] = b_op[g];
  end

  assign mul_finish = man_mode ? man_finish : auto_finish;
  assign mul_p = man_mode ? man_p : auto_p;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- sequential multiplier model ----------------
  initial begin
    int cnt;
    logic [31:0] pa;
    logic [31:0] pb;
    auto_finish = 1'b0;
    auto_p = '0;
    cnt = 0;
    pa = '0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (mul_start && !man_mode) begin
        pa = mul_a;
        pb = mul_b;
        auto_finish = 1'b0;
        auto_p = {$urandom, $urandom};
        cnt = (fixed_lat > 0) ? fixed_lat : $urandom_range(2, 6);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          auto_finish = 1'b1;
          auto_p = 64'(pa) * 64'(pb);
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotating priority: the winner is the set requester at the smallest distance past the last grant.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r, input int last);
    int best;
    int bestd;
    int d;
    best = 0;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - last - 1 + 2 * NREQ) % NREQ;
      if (r[i] && d < bestd) begin
        best = i;
        bestd = d;
      end
    end
    return {bestd < NREQ, IDW'(best)};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int m_last;
  logic prev_start;
  logic [NREQ-1:0] prev_done;

  always @(posedge clk) begin
    logic [IDW:0] p;
    logic [EW-1:0] e;
    logic [IDW-1:0] pid;
    #1;
    if (!rst_n) begin
      m_last = NREQ - 1;
      exp_q.delete();
      prev_start = 1'b0;
      prev_done = '0;
    end else begin
      if (mul_start) begin
        check("start_one_cycle", prev_start, 1'b0);
        check("start_busy", busy, 1'b1);
        p = rr_pick(req, m_last);
        check("start_has_req", p[IDW], 1'b1);
        pid = p[IDW-1:0];
        check("grant_id", grant_id, pid);
        check("mul_a", mul_a, a_op[pid]);
        check("mul_b", mul_b, b_op[pid]);
        exp_q.push_back({pid, to_mode ? 64'h0 : 64'(a_op[pid]) * 64'(b_op[pid])});
        m_last = int'(pid);
      end
      if (done != '0) begin
        check("done_one_cycle", prev_done, '0);
        if (exp_q.size() == 0) begin
          check("done_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          pid = e[EW-1:64];
          check("done_onehot", done, NREQ'(1) << pid);
          check("res", res, e[63:0]);
          check("err", err, to_mode);
        end
      end
      prev_start = mul_start;
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output logic [NREQ-1:0] d, output logic [63:0] r,
                           output logic e, output logic [IDW-1:0] g);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (done == '0 && k < 200);
    check("done_seen", done != '0, 1'b1);
    d = done;
    r = res;
    e = err;
    g = grant_id;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (busy && k < 100);
    check("back_to_idle", busy, 1'b0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    int idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [NREQ-1:0] exp_done;
    logic [IDW-1:0] exp_id;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [NREQ-1:0] d;
    logic [63:0] r;
    logic e;
    logic [IDW-1:0] g;
    int n;
    int k;

    vecs[0] = '{4'b0001, 0, 32'd351, 32'd23, 4'b0001, 2'd0, 64'h0000_0000_0000_1F89};
    vecs[1] = '{4'b0010, 1, 32'hFFFF_FFFE, 32'd3, 4'b0010, 2'd1, 64'h0000_0002_FFFF_FFFA};
    vecs[2] = '{4'b0100, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, 2'd2, 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{4'b1000, 3, 32'h0, 32'd12345678, 4'b1000, 2'd3, 64'h0};
    vecs[4] = '{4'b0001, 0, 32'h0001_0000, 32'h0001_0000, 4'b0001, 2'd0, 64'h0000_0001_0000_0000};
    vecs[5] = '{4'b1000, 3, 32'd1, 32'hDEAD_BEEF, 4'b1000, 2'd3, 64'h0000_0000_DEAD_BEEF};

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = '0;
    man_mode = 1'b0;
    man_finish = 1'b0;
    man_p = '0;
    fixed_lat = 0;
    to_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", done, '0);
    check("rst_res", res, '0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, '0);
    check("rst_mul_a", mul_a, '0);
    check("rst_mul_b", mul_b, '0);
    check("rst_mul_start", mul_start, 1'b0);

    // all requesters held high from reset: grants rotate 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = 32'(1000 * i + 7);
      b_op[i] = 32'h100 + 32'(i);
    end
    req = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_done(d, r, e, g);
      check("rot_id", g, j % NREQ);
      check("rot_done", d, NREQ'(1) << (j % NREQ));
      check("rot_res", r, 64'(a_op[j % NREQ]) * 64'(b_op[j % NREQ]));
    end
    @(negedge clk);
    req = '0;
    wait_idle();

    // single-request table
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      a_op[vecs[v].idx] = vecs[v].a;
      b_op[vecs[v].idx] = vecs[v].b;
      req = vecs[v].req;
      wait_done(d, r, e, g);
      check("vec_done", d, vecs[v].exp_done);
      check("vec_grant_id", g, vecs[v].exp_id);
      check("vec_res", r, vecs[v].exp_res);
      check("vec_err", e, 1'b0);
      @(negedge clk);
      req = '0;
      wait_idle();
    end

    // stale finish: a finish already high must not complete the new operation
    @(negedge clk);
    man_mode = 1'b1;
    man_finish = 1'b1;
    man_p = 64'hDEAD_0000_BAD0_0BAD;
    a_op[2] = 32'd1000;
    b_op[2] = 32'd77;
    req = 4'b0100;
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done != '0) n++;
    end
    check("stale_no_done", n, 0);
    check("stale_busy", busy, 1'b1);
    @(negedge clk);
    man_finish = 1'b0;
    man_p = 64'h0000_1234_5678_0000;
    repeat (2) @(negedge clk);
    man_p = 64'd77000;
    man_finish = 1'b1;
    wait_done(d, r, e, g);
    check("stale_done", d, 4'b0100);
    check("stale_res", r, 64'd77000);
    check("stale_grant_id", g, 2'd2);
    @(negedge clk);
    req = '0;
    wait_idle();
    @(negedge clk);
    man_mode = 1'b0;

    // reset in WAIT aborts silently and restores requester 0's priority
    fixed_lat = 40;
    a_op[0] = 32'd5;
    b_op[0] = 32'd6;
    a_op[3] = 32'd9;
    b_op[3] = 32'd9;
    req = 4'b0001;
    repeat (8) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_done", done, '0);
    check("arst_res", res, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_grant_id", grant_id, '0);
    check("arst_mul_a", mul_a, '0);
    check("arst_mul_b", mul_b, '0);
    check("arst_mul_start", mul_start, 1'b0);
    check("arst_err", err, 1'b0);
    req = 4'b1001;
    fixed_lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(d, r, e, g);
    check("post_rst_done", d, 4'b0001);
    check("post_rst_res", r, 64'd30);
    @(negedge clk);
    req = 4'b1000;
    wait_done(d, r, e, g);
    check("post_rst_done2", d, 4'b1000);
    check("post_rst_res2", r, 64'd81);
    @(negedge clk);
    req = '0;
    wait_idle();

`ifdef MUL_TIMEOUT_EN
    // watchdog: finish never rises
    @(negedge clk);
    man_mode = 1'b1;
    man_finish = 1'b0;
    to_mode = 1'b1;
    a_op[1] = 32'd3;
    b_op[1] = 32'd4;
    req = 4'b0010;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!mul_start && k < 20);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done == '0 && n < 100);
    check("timeout_cycles", n - 1, 16);
    check("timeout_done", done, 4'b0010);
    check("timeout_err", err, 1'b1);
    check("timeout_res", res, '0);
    @(negedge clk);
    req = '0;
    wait_idle();
    @(negedge clk);
    to_mode = 1'b0;
    man_mode = 1'b0;
`endif

    // random traffic against the reference model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            req[i] = 1'b0;
          end else begin
            a_op[i] = rnd32();
            b_op[i] = rnd32();
          end
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          a_op[i] = rnd32();
          b_op[i] = rnd32();
          req[i] = 1'b1;
        end
      end
    end
    k = 0;
    while ((req != '0 || busy) && k < 500) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) req[i] = 1'b0;
      end
      k++;
    end
    check("drain_req", req, '0);
    check("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
